// File: rtl/pipe_launch_if.sv
// Handshake bundle between a launch requester and pipe_launch_ctrl.
// The gap field exists only when LAUNCH_GAP_EN is defined.
interface pipe_launch_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             ret;
`ifdef LAUNCH_GAP_EN
    logic [3:0]       gap;
`endif
    logic             ready;
    logic             en;
    logic             busy;
    logic [4:0]       inflight;
    logic             done;
    logic             err;

`ifdef LAUNCH_GAP_EN
    modport master (output start, len, abort, ret, gap,
                    input  ready, en, busy, inflight, done, err);
    modport slave  (input  start, len, abort, ret, gap,
                    output ready, en, busy, inflight, done, err);
`else
    modport master (output start, len, abort, ret,
                    input  ready, en, busy, inflight, done, err);
    modport slave  (input  start, len, abort, ret,
                    output ready, en, busy, inflight, done, err);
`endif
endinterface

// File: rtl/pipe_launch_ctrl.sv
// Burst launcher feeding a DEPTH-stage enable chain; tracks items in flight.
// Optional inter-item gap enabled by defining LAUNCH_GAP_EN.
module pipe_launch_ctrl #(
    parameter int DEPTH = 15,
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    pipe_launch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [4:0]       inflight_q, inflight_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             proto_err;
`ifdef LAUNCH_GAP_EN
    logic [3:0]       gap_q, gap_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
`endif

    always_comb begin
        // NOTE: every next-state value is defaulted first so no branch can infer a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        inflight_d  = inflight_q;
        en_d        = en_q;
        done_d      = 1'b0;
        err_d       = err_q;
        proto_err   = 1'b0;
`ifdef LAUNCH_GAP_EN
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
`endif

        // Occupancy: a launch and a return in the same cycle cancel out.
        case ({en_q, bus.ret})
            2'b10: begin
                if (inflight_q >= DEPTH_C) begin
                    inflight_d = DEPTH_C;
                    proto_err  = 1'b1;
                end else begin
                    inflight_d = inflight_q + 5'd1;
                end
            end
            2'b01: begin
                if (inflight_q == 5'd0) proto_err  = 1'b1;
                else                    inflight_d = inflight_q - 5'd1;
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.len;
                    err_d       = 1'b0;
`ifdef LAUNCH_GAP_EN
                    gap_d       = bus.gap;
                    gap_cnt_d   = 4'd0;
`endif
                    if (bus.len != '0) begin
                        state_d = ISSUE;
                        en_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
`ifdef LAUNCH_GAP_EN
                if (!en_q) begin
                    // Inside an inter-item gap: count down, relaunch on the last gap cycle.
                    if (bus.abort) begin
                        state_d     = DRAIN;
                        remaining_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                        en_d      = (gap_cnt_q == 4'd1);
                    end
                end else
`endif
                if (bus.abort || remaining_q == LEN_W'(1)) begin
                    state_d     = DRAIN;
                    en_d        = 1'b0;
                    remaining_d = '0;
                end else begin
                    remaining_d = remaining_q - LEN_W'(1);
`ifdef LAUNCH_GAP_EN
                    en_d      = (gap_q == 4'd0);
                    gap_cnt_d = gap_q;
`else
                    en_d      = 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (inflight_d == 5'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (proto_err) err_d = 1'b1;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            inflight_q  <= 5'd0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
`ifdef LAUNCH_GAP_EN
            gap_q       <= 4'd0;
            gap_cnt_q   <= 4'd0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            en_q        <= en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
`ifdef LAUNCH_GAP_EN
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign bus.ready    = ready_q;
    assign bus.en       = en_q;
    assign bus.busy     = busy_q;
    assign bus.inflight = inflight_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_pipe_launch_ctrl.sv
// Self-checking bench for pipe_launch_ctrl: directed scenarios plus random bursts
// checked against a cycle-list model; the return path is a DEPTH-deep shift chain.
module tb_pipe_launch_ctrl;
    localparam int DEPTH = 15;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_launch_if #(.LEN_W(LEN_W)) bus ();

    pipe_launch_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment: downstream delay chain, with a mute and a manual injection hook.
    logic [DEPTH-1:0] chain_q = '0;
    logic             mute    = 1'b0;
    logic             inj_ret = 1'b0;
    always @(posedge clk) chain_q <= {chain_q[DEPTH-2:0], bus.en};
    assign bus.ret = (chain_q[DEPTH-1] & ~mute) | inj_ret;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_burst(input int len, input int g);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LEN_W'(len);
`ifdef LAUNCH_GAP_EN
        bus.gap   = 4'(g);
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.len   = LEN_W'($urandom);
    endtask

    // Model: item i launches in cycle 1+i*(g+1), returns DEPTH cycles later.
    // Cycle k is the period right after edge k-1; start is sampled at edge 0.
    task automatic run_burst(input string name, input int len, input int abort_at,
                             input int g, input bit junk);
        int issued, done_c, ncyc, junk_at, n_in, c;
        logic exp_en;
        issued = 0;
        for (int i = 0; i < len; i++)
            if (abort_at == 0 || 1 + i * (g + 1) <= abort_at) issued++;
        done_c  = (issued == 0) ? 1 : 1 + (issued - 1) * (g + 1) + DEPTH + 1;
        ncyc    = done_c + 2;
        junk_at = junk ? int'($urandom_range(1, done_c)) : 0;
        start_burst(len, g);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            exp_en = 1'b0;
            n_in   = 0;
            for (int i = 0; i < issued; i++) begin
                c = 1 + i * (g + 1);
                if (c == k)              exp_en = 1'b1;
                if (c <= k - 1)          n_in++;
                if (c + DEPTH <= k - 1)  n_in--;
            end
            chk({name, ".en"},       32'(bus.en),       32'(exp_en));
            chk({name, ".done"},     32'(bus.done),     32'(k == done_c));
            chk({name, ".busy"},     32'(bus.busy),     32'(k <= done_c));
            chk({name, ".ready"},    32'(bus.ready),    32'(k > done_c));
            chk({name, ".inflight"}, 32'(bus.inflight), 32'(n_in));
            chk({name, ".err"},      32'(bus.err),      32'(0));
            bus.abort = (k == abort_at);
            bus.start = (k == junk_at);
            if (k == junk_at) bus.len = LEN_W'($urandom);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int len, ab, g;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
        bus.abort = 1'b0;
`ifdef LAUNCH_GAP_EN
        bus.gap   = 4'd0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.ready",    32'(bus.ready),    32'(1));
        chk("rst.en",       32'(bus.en),       32'(0));
        chk("rst.busy",     32'(bus.busy),     32'(0));
        chk("rst.done",     32'(bus.done),     32'(0));
        chk("rst.err",      32'(bus.err),      32'(0));
        chk("rst.inflight", 32'(bus.inflight), 32'(0));
        rst = 1'b1;

        // Basic, empty, chain-filling and aborted bursts
        run_burst("len4",   4,  0, 0, 1'b0);
        run_burst("len0",   0,  0, 0, 1'b0);
        run_burst("len40",  40, 0, 0, 1'b0);
        run_burst("abort3", 10, 3, 0, 1'b0);

        // Stray return while idle raises err, count stays 0; next start clears err
        @(negedge clk);
        inj_ret = 1'b1;
        @(negedge clk);
        inj_ret = 1'b0;
        chk("stray.err",      32'(bus.err),      32'(1));
        chk("stray.inflight", 32'(bus.inflight), 32'(0));
        chk("stray.ready",    32'(bus.ready),    32'(1));
        run_burst("clear", 2, 0, 0, 1'b0);

        // Returns suppressed: count saturates at DEPTH and err latches
        mute = 1'b1;
        start_burst(20, 0);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            chk("sat.inflight", 32'(bus.inflight), 32'((k - 1 < DEPTH) ? k - 1 : DEPTH));
            chk("sat.err",      32'(bus.err),      32'(k >= DEPTH + 2));
            chk("sat.busy",     32'(bus.busy),     32'(1));
        end
        #2 rst = 1'b0;
        repeat (DEPTH + 2) @(negedge clk);
        mute = 1'b0;
        rst  = 1'b1;

        // Reset in cycle 5 of an 8-item burst; late returns then raise err
        start_burst(8, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("mid.en", 32'(bus.en), 32'(1));
        end
        #2 rst = 1'b0;
        #1;
        chk("mid.rst.en",    32'(bus.en),    32'(0));
        chk("mid.rst.busy",  32'(bus.busy),  32'(0));
        chk("mid.rst.ready", 32'(bus.ready), 32'(1));
        chk("mid.rst.done",  32'(bus.done),  32'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 7; k <= 26; k++) begin
            @(negedge clk);
            chk("late.done",     32'(bus.done),     32'(0));
            chk("late.busy",     32'(bus.busy),     32'(0));
            chk("late.inflight", 32'(bus.inflight), 32'(0));
            chk("late.err",      32'(bus.err),      32'(k >= DEPTH + 2));
        end
        run_burst("reclear", 5, 0, 0, 1'b0);

`ifdef LAUNCH_GAP_EN
        run_burst("gap2", 3, 0, 2, 1'b0);
`endif

        // Random bursts with occasional aborts and ignored starts while busy
        for (int t = 0; t < 14; t++) begin
            len = int'($urandom_range(0, 40));
            ab  = ($urandom_range(0, 2) == 0 && len != 0) ? int'($urandom_range(1, len + 2)) : 0;
`ifdef LAUNCH_GAP_EN
            g   = int'($urandom_range(0, 7));
`else
            g   = 0;
`endif
            run_burst("rand", len, ab, g, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
